// File: rtl/rasp_link_rx_pkg.sv
// Shared constants, state encodings and the frame checksum helper for the Pi status link receiver.
package rasp_link_rx_pkg;

   localparam logic [7:0] HDR_BYTE       = 8'hA5;
   localparam int         STAT_INSIGHT   = 0;
   localparam int         STAT_CLOSE     = 1;
   localparam logic [7:0] STAT_RSVD_MASK = 8'hFC;

   typedef enum logic [1:0] {
      P_WAIT_HDR = 2'd0,
      P_GET_STAT = 2'd1,
      P_GET_CHK  = 2'd2
   } parse_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   typedef enum logic [1:0] {
      EV_NONE   = 2'd0,
      EV_ACCEPT = 2'd1,
      EV_REJECT = 2'd2
   } parse_evt_e;

   function automatic logic [7:0] frame_chk(input logic [7:0] stat);
      return HDR_BYTE ^ stat;
   endfunction

endpackage

// File: rtl/rasp_link_rx_if.sv
// Pi status link bundle: the UART line in, the robot-facing status flags out.
interface rasp_link_rx_if;

   logic       rasp_rx;
   logic       rasp_on;
   logic       obj_inSight;
   logic       obj_isClose;
   logic       frame_valid;
   logic [7:0] err_cnt;

   modport master (
      output rasp_rx,
      input  rasp_on, obj_inSight, obj_isClose, frame_valid, err_cnt
   );

   modport slave (
      input  rasp_rx,
      output rasp_on, obj_inSight, obj_isClose, frame_valid, err_cnt
   );

endinterface

// File: rtl/rasp_link_rx_uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, start-bit glitch filter, mid-bit sampler, LSB-first shifter.
module uart_rx_byte
   import rasp_link_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic       byte_ok_o,
   output logic [7:0] byte_data_o,
   output logic       frame_err_o
);

   localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rx_s;
   rx_state_e              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             data_q, data_d;
   logic                   ok_q, ok_d;
   logic                   ferr_q, ferr_d;

   assign rx_s = sync_q[SYNC_STAGES-1];

   // Synchronizer chain resets to the idle-high line level so reset never fakes a start edge
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
         prev_q <= rx_s;
      end
   end

   // Receiver state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         data_q  <= 8'd0;
         ok_q    <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         ok_q    <= ok_d;
         ferr_q  <= ferr_d;
      end
   end

   // Bit timer and sampling decisions
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      ok_d    = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (prev_q && !rx_s) begin
               state_d = RX_START;
            end else begin
               state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               bit_d = 3'd0;
               // a start bit that is high again at mid-bit was only a glitch
               if (!rx_s) begin
                  state_d = RX_DATA;
               end else begin
                  state_d = RX_IDLE;
               end
            end else begin
               state_d = RX_START;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               state_d = RX_DATA;
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               if (rx_s) begin
                  ok_d   = 1'b1;
                  data_d = shift_q;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               state_d = RX_STOP;
            end
         end
         default: begin
            state_d = RX_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign byte_ok_o   = ok_q;
   assign byte_data_o = data_q;
   assign frame_err_o = ferr_q;

endmodule

// File: rtl/rasp_link_rx.sv
// Pi status link receiver: frame parser, heartbeat timeout and registered robot status flags.
// Optional rejected-frame counter built only when ROBINHO_LINK_ERRCNT_EN is defined.
module rasp_link_rx
   import rasp_link_rx_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int BAUD           = 115_200,
   parameter int TIMEOUT_CYCLES = 25_000_000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic           clk,
   input  logic           rst,
   rasp_link_rx_if.slave  link
);

   localparam int            CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int            TO_W         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_MAX     = TO_W'(TIMEOUT_CYCLES);

   logic         byte_ok_s;
   logic [7:0]   byte_data_s;
   logic         frame_err_s;

   parse_state_e pstate_q, pstate_d;
   logic [7:0]   stat_q, stat_d;
   parse_evt_e   evt_s;

   logic            rasp_on_q, rasp_on_d;
   logic            insight_q, insight_d;
   logic            close_q, close_d;
   logic            fv_q, fv_d;
   logic [TO_W-1:0] to_q, to_d;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .SYNC_STAGES  (SYNC_STAGES)
   ) u_rx (
      .clk         (clk),
      .rst         (rst),
      .rx_i        (link.rasp_rx),
      .byte_ok_o   (byte_ok_s),
      .byte_data_o (byte_data_s),
      .frame_err_o (frame_err_s)
   );

   // Parser state and latched status byte
   always_ff @(posedge clk) begin
      if (rst) begin
         pstate_q <= P_WAIT_HDR;
         stat_q   <= 8'd0;
      end else begin
         pstate_q <= pstate_d;
         stat_q   <= stat_d;
      end
   end

   // Frame parser: a header seen where STAT or CHK was expected restarts the frame from it
   always_comb begin
      pstate_d = pstate_q;
      stat_d   = stat_q;
      evt_s    = EV_NONE;
      if (frame_err_s) begin
         evt_s    = EV_REJECT;
         pstate_d = P_WAIT_HDR;
      end else if (byte_ok_s) begin
         case (pstate_q)
            P_WAIT_HDR: begin
               if (byte_data_s == HDR_BYTE) begin
                  pstate_d = P_GET_STAT;
               end else begin
                  pstate_d = P_WAIT_HDR;
               end
            end
            P_GET_STAT: begin
               if (byte_data_s == HDR_BYTE) begin
                  pstate_d = P_GET_STAT;
               end else if ((byte_data_s & STAT_RSVD_MASK) != 8'd0) begin
                  evt_s    = EV_REJECT;
                  pstate_d = P_WAIT_HDR;
               end else begin
                  stat_d   = byte_data_s;
                  pstate_d = P_GET_CHK;
               end
            end
            P_GET_CHK: begin
               if (byte_data_s == frame_chk(stat_q)) begin
                  evt_s    = EV_ACCEPT;
                  pstate_d = P_WAIT_HDR;
               end else if (byte_data_s == HDR_BYTE) begin
                  evt_s    = EV_REJECT;
                  pstate_d = P_GET_STAT;
               end else begin
                  evt_s    = EV_REJECT;
                  pstate_d = P_WAIT_HDR;
               end
            end
            default: begin
               pstate_d = P_WAIT_HDR;
            end
         endcase
      end else begin
         pstate_d = pstate_q;
      end
   end

   // Output flags and heartbeat counter
   always_ff @(posedge clk) begin
      if (rst) begin
         rasp_on_q <= 1'b0;
         insight_q <= 1'b0;
         close_q   <= 1'b0;
         fv_q      <= 1'b0;
         to_q      <= '0;
      end else begin
         rasp_on_q <= rasp_on_d;
         insight_q <= insight_d;
         close_q   <= close_d;
         fv_q      <= fv_d;
         to_q      <= to_d;
      end
   end

   // Accept has priority over an expiring heartbeat in the same cycle
   always_comb begin
      rasp_on_d = rasp_on_q;
      insight_d = insight_q;
      close_d   = close_q;
      to_d      = to_q;
      fv_d      = (evt_s == EV_ACCEPT);
      if (evt_s == EV_ACCEPT) begin
         rasp_on_d = 1'b1;
         insight_d = stat_q[STAT_INSIGHT] | stat_q[STAT_CLOSE];
         close_d   = stat_q[STAT_CLOSE];
         to_d      = '0;
      end else if (rasp_on_q) begin
         if (to_q == TO_MAX) begin
            rasp_on_d = 1'b0;
            insight_d = 1'b0;
            close_d   = 1'b0;
         end else begin
            to_d = to_q + TO_W'(1);
         end
      end else begin
         to_d = to_q;
      end
   end

`ifdef ROBINHO_LINK_ERRCNT_EN
   logic [7:0] err_q, err_d;

   // Rejected-frame counter, saturating, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 8'd0;
      end else begin
         err_q <= err_d;
      end
   end

   // Next count for the rejected-frame counter
   always_comb begin
      err_d = err_q;
      if ((evt_s == EV_REJECT) && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end else begin
         err_d = err_q;
      end
   end

   assign link.err_cnt = err_q;
`else
   assign link.err_cnt = 8'd0;
`endif

   assign link.rasp_on     = rasp_on_q;
   assign link.obj_inSight = insight_q;
   assign link.obj_isClose = close_q;
   assign link.frame_valid = fv_q;

endmodule

// File: tb/tb_rasp_link_rx.sv
// Directed self-checking bench for rasp_link_rx at 10 clocks per bit and a 2000-cycle heartbeat.
module tb_rasp_link_rx;

   localparam int BIT = 10;
`ifdef ROBINHO_LINK_ERRCNT_EN
   localparam bit ERRCNT = 1'b1;
`else
   localparam bit ERRCNT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   fv_cnt = 0;
   int   fv_long = 0;
   logic fv_prev = 1'b0;

   rasp_link_rx_if link();

   rasp_link_rx #(
      .CLK_HZ         (1_000_000),
      .BAUD           (100_000),
      .TIMEOUT_CYCLES (2000),
      .SYNC_STAGES    (2)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .link (link)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (link.frame_valid === 1'b1) fv_cnt++;
      if (link.frame_valid === 1'b1 && fv_prev === 1'b1) fv_long++;
      fv_prev = link.frame_valid;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      link.rasp_rx = 1'b0;
      idle(BIT);
      for (int i = 0; i < 8; i++) begin
         link.rasp_rx = b[i];
         idle(BIT);
      end
      link.rasp_rx = stop;
      idle(BIT);
      link.rasp_rx = 1'b1;
      idle(2);
   endtask

   task automatic send_frame(input logic [7:0] h, input logic [7:0] s, input logic [7:0] c);
      send_byte(h, 1'b1);
      send_byte(s, 1'b1);
      send_byte(c, 1'b1);
      idle(10);
   endtask

   task automatic check_outs(input string nm, input logic on, input logic ins, input logic cls, input logic [7:0] ec);
      checks++;
      if ({link.rasp_on, link.obj_inSight, link.obj_isClose} !== {on, ins, cls}) begin
         errors++;
         $display("FAIL %s flags: got on/ins/cls=%b%b%b expected %b%b%b", nm,
                  link.rasp_on, link.obj_inSight, link.obj_isClose, on, ins, cls);
      end
      checks++;
      if (link.err_cnt !== ec) begin
         errors++;
         $display("FAIL %s err_cnt: got %0d expected %0d", nm, link.err_cnt, ec);
      end
   endtask

   task automatic test_reset();
      link.rasp_rx = 1'b1;
      rst = 1'b1;
      idle(5);
      check_outs("reset", 1'b0, 1'b0, 1'b0, 8'd0);
      checks++;
      if (link.frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset frame_valid: got %b expected 0", link.frame_valid);
      end
      rst = 1'b0;
      idle(20);
   endtask

   task automatic test_accept();
      int f0;
      f0 = fv_cnt;
      send_frame(8'hA5, 8'h02, 8'hA7);
      checks++;
      if (fv_cnt - f0 !== 1 || fv_long !== 0) begin
         errors++;
         $display("FAIL accept pulse: got %0d pulses, %0d long, expected 1 pulse 0 long", fv_cnt - f0, fv_long);
      end
      check_outs("accept", 1'b1, 1'b1, 1'b1, 8'd0);
   endtask

   task automatic test_timeout();
      int f0;
      f0 = fv_cnt;
      send_frame(8'hA5, 8'h01, 8'hA4);
      check_outs("pre_timeout_flags", 1'b1, 1'b1, 1'b0, 8'd0);
      idle(1950);
      check_outs("before_timeout", 1'b1, 1'b1, 1'b0, 8'd0);
      idle(80);
      check_outs("after_timeout", 1'b0, 1'b0, 1'b0, 8'd0);
      checks++;
      if (fv_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL timeout pulses: got %0d expected 1", fv_cnt - f0);
      end
   endtask

   task automatic test_resync();
      int f0;
      f0 = fv_cnt;
      send_frame(8'hA5, 8'h01, 8'hA5);
      check_outs("bad_chk", 1'b0, 1'b0, 1'b0, ERRCNT ? 8'd1 : 8'd0);
      send_byte(8'h01, 1'b1);
      send_byte(8'hA4, 1'b1);
      idle(10);
      check_outs("resync", 1'b1, 1'b1, 1'b0, ERRCNT ? 8'd1 : 8'd0);
      checks++;
      if (fv_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL resync pulses: got %0d expected 1", fv_cnt - f0);
      end
   endtask

   task automatic test_reserved();
      int f0;
      f0 = fv_cnt;
      send_frame(8'hA5, 8'h05, 8'hA0);
      check_outs("reserved", 1'b1, 1'b1, 1'b0, ERRCNT ? 8'd2 : 8'd0);
      checks++;
      if (fv_cnt - f0 !== 0) begin
         errors++;
         $display("FAIL reserved pulses: got %0d expected 0", fv_cnt - f0);
      end
   endtask

   task automatic test_framing_glitch();
      int f0;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b0);
      idle(10);
      check_outs("framing", 1'b1, 1'b1, 1'b0, ERRCNT ? 8'd3 : 8'd0);
      send_frame(8'hA5, 8'h00, 8'hA5);
      check_outs("after_framing", 1'b1, 1'b0, 1'b0, ERRCNT ? 8'd3 : 8'd0);
      // a glitch between header and status would inject a reserved-bit byte if it were taken
      f0 = fv_cnt;
      send_byte(8'hA5, 1'b1);
      idle(10);
      link.rasp_rx = 1'b0;
      idle(3);
      link.rasp_rx = 1'b1;
      idle(30);
      send_byte(8'h01, 1'b1);
      send_byte(8'hA4, 1'b1);
      idle(10);
      check_outs("glitch", 1'b1, 1'b1, 1'b0, ERRCNT ? 8'd3 : 8'd0);
      checks++;
      if (fv_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL glitch pulses: got %0d expected 1", fv_cnt - f0);
      end
   endtask

   task automatic test_mid_reset();
      int f0;
      send_byte(8'hA5, 1'b1);
      link.rasp_rx = 1'b0;
      idle(BIT);
      link.rasp_rx = 1'b1;
      idle(BIT);
      link.rasp_rx = 1'b0;
      idle(BIT + 3);
      rst = 1'b1;
      link.rasp_rx = 1'b1;
      idle(2);
      check_outs("in_reset", 1'b0, 1'b0, 1'b0, 8'd0);
      idle(3);
      rst = 1'b0;
      idle(20);
      check_outs("post_reset_idle", 1'b0, 1'b0, 1'b0, 8'd0);
      f0 = fv_cnt;
      send_frame(8'hA5, 8'h01, 8'hA4);
      check_outs("post_reset_frame", 1'b1, 1'b1, 1'b0, 8'd0);
      checks++;
      if (fv_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL post_reset pulses: got %0d expected 1", fv_cnt - f0);
      end
   endtask

   initial begin
      link.rasp_rx = 1'b1;
      test_reset();
      test_accept();
      test_timeout();
      test_resync();
      test_reserved();
      test_framing_glitch();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
